// File: rtl/ber_scan_checker.sv
// Bit-error-rate checker: scans every candidate reference delay, locks on the best one and
// accumulates long-run error/bit counts. Optional relock on a bad locked window: BER_SCAN_RELOCK_EN.
module ber_scan_checker #(
  parameter int PRBS_LEN   = 511,
  parameter int MAX_DELAY  = 511,
  parameter int ACC_W      = 32,
  parameter int PHASE_W    = 2,
`ifdef BER_SCAN_RELOCK_EN
  parameter int RELOCK_THR = 64,
`endif
  localparam int DLY_W     = $clog2(MAX_DELAY),
  localparam int ERR_W     = $clog2(PRBS_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic               i_bit_ref,
  input  logic               i_bit_rx,
  input  logic [PHASE_W-1:0] i_phase,
  output logic               o_locked,
  output logic [1:0]         o_state,
  output logic [DLY_W-1:0]   o_delay,
  output logic [ERR_W-1:0]   o_min_err,
  output logic [ACC_W-1:0]   o_err_acc,
`ifdef BER_SCAN_RELOCK_EN
  output logic [7:0]         o_relock_cnt,
`endif
  output logic [ACC_W-1:0]   o_bit_acc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t               state;
  logic [MAX_DELAY-2:0] dline;
  logic [MAX_DELAY-1:0] taps;
  logic [DLY_W-1:0]     cand;
  logic [DLY_W-1:0]     tap_sel;
  logic [ERR_W-1:0]     win_cnt;
  logic [ERR_W-1:0]     err_cnt;
  logic [ERR_W-1:0]     win_total;
  logic [PHASE_W-1:0]   phase_q;
  logic                 en_q;
  logic                 err_bit;
  logic                 win_last;
  logic                 last_cand;
  logic                 restart;
  logic                 relock;

  // Tap 0 is the live reference bit; tap d>0 is the bit seen d valid strobes earlier.
  assign taps      = {dline, i_bit_ref};
  assign tap_sel   = (state == LOCK) ? o_delay : cand;
  assign err_bit   = taps[tap_sel] ^ i_bit_rx;
  assign win_total = err_cnt + {{(ERR_W-1){1'b0}}, err_bit};
  assign win_last  = (win_cnt == ERR_W'(PRBS_LEN - 1));
  assign last_cand = (cand == DLY_W'(MAX_DELAY - 1));
  assign restart   = i_enable && (!en_q || (i_phase != phase_q));
  assign o_state   = state;

`ifdef BER_SCAN_RELOCK_EN
  assign relock = i_enable && i_valid && (state == LOCK) && win_last &&
                  (32'(win_total) >= 32'(RELOCK_THR));
`else
  assign relock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      o_locked  <= 1'b0;
      o_delay   <= '0;
      o_min_err <= '1;
      o_err_acc <= '0;
      o_bit_acc <= '0;
      dline     <= '0;
      win_cnt   <= '0;
      err_cnt   <= '0;
      cand      <= '0;
      phase_q   <= '0;
      en_q      <= 1'b0;
`ifdef BER_SCAN_RELOCK_EN
      o_relock_cnt <= '0;
`endif
    end else begin
      // NOTE: every register here uses <= so all decisions below see pre-edge values.
      en_q    <= i_enable;
      phase_q <= i_phase;
      if (i_valid) dline <= taps[MAX_DELAY-2:0];

`ifdef BER_SCAN_RELOCK_EN
      if (relock && !restart && o_relock_cnt != 8'hFF) o_relock_cnt <= o_relock_cnt + 1'b1;
`endif

      // Restart (enable edge, phase change or bad locked window) drops the in-flight bit.
      if (restart || relock) begin
        state     <= SEARCH;
        o_locked  <= 1'b0;
        o_min_err <= '1;
        o_err_acc <= '0;
        o_bit_acc <= '0;
        win_cnt   <= '0;
        err_cnt   <= '0;
        cand      <= '0;
      end else if (!i_enable) begin
        state    <= IDLE;
        o_locked <= 1'b0;
      end else if (i_valid) begin
        case (state)
          SEARCH: begin
            if (win_last) begin
              if (win_total < o_min_err) begin
                o_min_err <= win_total;
                o_delay   <= cand;
              end
              win_cnt <= '0;
              err_cnt <= '0;
              if (last_cand) begin
                state    <= LOCK;
                o_locked <= 1'b1;
              end else begin
                cand <= cand + 1'b1;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
              err_cnt <= win_total;
            end
          end
          LOCK: begin
            if (o_bit_acc != ACC_MAX) begin
              o_bit_acc <= o_bit_acc + 1'b1;
              if (o_err_acc != ACC_MAX) o_err_acc <= o_err_acc + {{(ACC_W-1){1'b0}}, err_bit};
            end
`ifdef BER_SCAN_RELOCK_EN
            if (win_last) begin
              win_cnt <= '0;
              err_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              err_cnt <= win_total;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ber_scan_checker.sv
// Randomized self-checking bench for ber_scan_checker; the reference model keeps the whole
// sample history and recomputes window error counts and locked totals by direct summation.
module tb_ber_scan_checker;

  localparam int PL      = 15;
  localparam int MD      = 16;
  localparam int ACC_W   = 10;
  localparam int PHASE_W = 2;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int ERR_MAX = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_enable = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_bit_ref = 1'b0;
  logic               i_bit_rx = 1'b0;
  logic [PHASE_W-1:0] i_phase = '0;
  logic               o_locked;
  logic [1:0]         o_state;
  logic [3:0]         o_delay;
  logic [3:0]         o_min_err;
  logic [ACC_W-1:0]   o_err_acc;
  logic [ACC_W-1:0]   o_bit_acc;
`ifdef BER_SCAN_RELOCK_EN
  logic [7:0]         o_relock_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit ref_h[$];
  bit rx_h[$];
  int seg_start = 0;
  int bit_no = 0;

  always #5 clk = ~clk;

  ber_scan_checker #(
    .PRBS_LEN(PL), .MAX_DELAY(MD), .ACC_W(ACC_W), .PHASE_W(PHASE_W)
`ifdef BER_SCAN_RELOCK_EN
    , .RELOCK_THR(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit_ref(i_bit_ref), .i_bit_rx(i_bit_rx), .i_phase(i_phase),
    .o_locked(o_locked), .o_state(o_state), .o_delay(o_delay), .o_min_err(o_min_err),
    .o_err_acc(o_err_acc),
`ifdef BER_SCAN_RELOCK_EN
    .o_relock_cnt(o_relock_cnt),
`endif
    .o_bit_acc(o_bit_acc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference bit of valid sample i since reset; anything before reset reads as 0.
  function automatic bit ref_at(input int i);
    return (i < 0) ? 1'b0 : ref_h[i];
  endfunction

  // Errors of candidate c's scan window in the current search segment.
  function automatic int win_err(input int c);
    int e = 0;
    for (int w = 0; w < PL; w++) begin
      int k = seg_start + c * PL + w;
      e += int'(ref_at(k - c) ^ rx_h[k]);
    end
    return e;
  endfunction

  function automatic void exp_scan(output int dly, output int mn);
    mn = ERR_MAX;
    dly = -1;
    for (int c = 0; c < MD; c++) begin
      int e = win_err(c);
      if (e < mn) begin
        mn = e;
        dly = c;
      end
    end
  endfunction

  function automatic void exp_acc(input int dly, output int bits, output int errs);
    bits = 0;
    errs = 0;
    for (int k = seg_start + PL * MD; k < ref_h.size(); k++) begin
      if (bits == ACC_MAX) break;
      bits++;
      errs += int'(ref_at(k - dly) ^ rx_h[k]);
    end
  endfunction

  task automatic step(input bit v, input bit rb, input bit xb);
    i_valid   = v;
    i_bit_ref = rb;
    i_bit_rx  = xb;
    @(posedge clk);
    #1;
    if (rst && v) begin
      ref_h.push_back(rb);
      rx_h.push_back(xb);
    end
  endtask

  // Random reference bit; receiver sees it dly valid strobes later, inverted every period-th bit.
  task automatic send(input int dly, input int period, input bit v);
    bit rb, xb, flip;
    int n;
    rb   = bit'($urandom % 2);
    n    = ref_h.size();
    flip = v && (period > 0) && (bit_no % period == period - 1);
    xb   = ((dly == 0) ? rb : ref_at(n - dly)) ^ flip;
    if (v) bit_no++;
    step(v, rb, xb);
  endtask

  // Restart edge driven with i_valid low; the search segment begins right after it.
  task automatic restart_step(input int dly);
    bit_no = 0;
    send(dly, 0, 1'b0);
    seg_start = ref_h.size();
  endtask

  task automatic run_n(input int n, input int dly, input int period);
    for (int i = 0; i < n; i++) send(dly, period, 1'b1);
  endtask

  task automatic run_to_lock(input int dly, input int period, input bit toggle, output int cycles);
    cycles = 0;
    while (!o_locked && cycles < 3000) begin
      send(dly, period, toggle ? (cycles % 2 == 0) : 1'b1);
      cycles++;
    end
    if (!o_locked) check("lock_timeout", o_locked, 1);
  endtask

  task automatic check_scan(input string tag);
    int dly, mn;
    exp_scan(dly, mn);
    check({tag, "_state"}, o_state, 2);
    check({tag, "_delay"}, o_delay, dly);
    check({tag, "_min_err"}, o_min_err, mn);
  endtask

  task automatic check_acc(input string tag);
    int bits, errs;
    exp_acc(int'(o_delay), bits, errs);
    check({tag, "_bit_acc"}, o_bit_acc, bits);
    check({tag, "_err_acc"}, o_err_acc, errs);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_delay"}, o_delay, 0);
    check({tag, "_min_err"}, o_min_err, ERR_MAX);
    check({tag, "_err_acc"}, o_err_acc, 0);
    check({tag, "_bit_acc"}, o_bit_acc, 0);
  endtask

  initial begin
    int cyc;
    logic [ACC_W-1:0] held;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b1;

    // Clean link, receiver 5 strobes behind the reference.
    i_enable = 1'b1;
    restart_step(5);
    check("t1_search", o_state, 1);
    run_to_lock(5, 0, 1'b0, cyc);
    check("t1_lock_bits", cyc, PL * MD);
    check_scan("t1");
    check("t1_delay5", o_delay, 5);
    run_n(1000, 5, 0);
    check_acc("t1");
    check("t1_bits1000", o_bit_acc, 1000);

    // Disable holds outputs but drops lock.
    i_enable = 1'b0;
    send(5, 0, 1'b1);
    check("dis_state", o_state, 0);
    check("dis_locked", o_locked, 0);
    check("dis_bit_hold", o_bit_acc, 1000);

    // Every 100th received bit inverted.
    i_enable = 1'b1;
    restart_step(5);
    run_to_lock(5, 100, 1'b0, cyc);
    check_scan("t2");
    check("t2_min_le1", o_min_err <= 1, 1);
    run_n(1000, 5, 100);
    check_acc("t2");
    check("t2_err10", o_err_acc, 10);

    // Valid strobe toggling 1/0: scan spans 480 cycles counting the restart cycle.
    i_enable = 1'b0;
    send(5, 0, 1'b0);
    i_enable = 1'b1;
    restart_step(5);
    run_to_lock(5, 37, 1'b1, cyc);
    check("t3_scan_cycles", cyc + 1, 480);
    check_scan("t3");
    held = o_bit_acc;
    send(5, 0, 1'b0);
    check("t3_frozen", o_bit_acc, held);
    send(5, 0, 1'b1);
    check("t3_moves", o_bit_acc, held + 1);
    // Long locked run with errors saturates the bit accumulator.
    run_n(1100, 5, 37);
    check_acc("t3_sat");
    check("t3_bit_sat", o_bit_acc, ACC_MAX);

    // Phase change on the last bit of candidate 5's window: restart wins, nothing latched.
    i_phase = 2'd1;
    restart_step(5);
    run_n(5 * PL + PL - 1, 5, 0);
    i_phase = 2'd2;
    send(5, 0, 1'b1);
    seg_start = ref_h.size();
    check("t4_edge_min_err", o_min_err, ERR_MAX);
    check("t4_edge_state", o_state, 1);
    // Phase change mid-window of candidate 7.
    run_n(7 * PL + 3, 5, 0);
    check("t4_pre_min_err", o_min_err, 0);
    i_phase = 2'd0;
    send(5, 0, 1'b1);
    seg_start = ref_h.size();
    check("t4_state", o_state, 1);
    check("t4_min_err_ones", o_min_err, ERR_MAX);
    check("t4_bit_clr", o_bit_acc, 0);
    run_to_lock(5, 0, 1'b0, cyc);
    check("t4_lock_bits", cyc, PL * MD);
    check_scan("t4");

    // One-cycle reset while locked.
    run_n(20, 5, 0);
    rst = 1'b0;
    send(5, 0, 1'b1);
    ref_h.delete();
    rx_h.delete();
    check_reset_vals("t5_rst");
    rst = 1'b1;
    restart_step(5);
    run_to_lock(5, 0, 1'b0, cyc);
    check_scan("t5");
    i_enable = 1'b0;
    send(5, 0, 1'b1);
    check("t5_dis_state", o_state, 0);
    check("t5_dis_locked", o_locked, 0);

`ifdef BER_SCAN_RELOCK_EN
    // Receiver slips to delay 9 while locked: bad window forces one relock.
    i_enable = 1'b1;
    restart_step(5);
    run_to_lock(5, 0, 1'b0, cyc);
    check("rl_cnt0", o_relock_cnt, 0);
    cyc = 0;
    while (o_relock_cnt == 0 && cyc < 300) begin
      send(9, 0, 1'b1);
      cyc++;
    end
    seg_start = ref_h.size();
    check("rl_cnt1", o_relock_cnt, 1);
    check("rl_state", o_state, 1);
    run_to_lock(9, 0, 1'b0, cyc);
    check_scan("rl");
    check("rl_delay9", o_delay, 9);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
